// File: rtl/dmem_mmio_pkg.sv
// -----------------------------------------------------------------------------
// dmem_mmio_pkg
// Shared definitions for the data-memory / MMIO stage:
//   - MMIO register addresses (OUT_DATA, STATUS, CYCLES)
//   - STATUS register bit positions
//   - region decode enum used by the address decoder
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_mmio_pkg;

    localparam logic [31:0] MMIO_OUT_DATA = 32'hFFFF_0000;
    localparam logic [31:0] MMIO_STATUS   = 32'hFFFF_0004;
    localparam logic [31:0] MMIO_CYCLES   = 32'hFFFF_0008;

    localparam int ST_FULL  = 16;
    localparam int ST_EMPTY = 17;
    localparam int ST_OVF   = 18;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_OUT,
        REG_STATUS,
        REG_CYCLES,
        REG_NONE
    } region_t;

endpackage

// File: rtl/dmem_mmio_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with show-ahead head data. The caller is responsible for
// qualifying the strobes: push must only be asserted when there is room (or a
// pop happens on the same edge), pop only when the FIFO is non-empty.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset (pointers/count only)
//   push, wdata    - write strobe and data
//   pop            - remove head entry
//   rdata          - head entry (don't-care while empty)
//   full, empty    - occupancy flags
//   count          - number of stored entries, log2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage carries data only, so it is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/dmem_mmio.sv
// -----------------------------------------------------------------------------
// dmem_mmio
// Data-memory stage for the single-cycle MIPS core: word RAM with
// combinational read / clocked write, a memory-mapped output queue drained by
// a valid/ready handshake, and a STATUS register with a sticky overflow flag.
// Optional feature macro: DMEM_MMIO_CYCLE_CNT_EN adds a free-running 32-bit
// cycle counter readable at MMIO_CYCLES; otherwise that address is unmapped.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   dmem_we/addr/wd      - store strobe, byte address, store data from the core
//   dmem_rd              - combinational load data
//   out_valid/ready/data - output queue handshake toward the peripheral
//   overflow             - sticky flag, set when a push is dropped
// -----------------------------------------------------------------------------
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wd,
    output logic [31:0] dmem_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        overflow
);

    localparam int RW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    region_t        region;
    logic [RW-1:0]  ram_idx;
    logic [31:0]    ram [RAM_WORDS];
    logic           push_req;
    logic           push_ok;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic [31:0]    status;

    // Byte-lane bits are not used for anything in a word-only map.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^dmem_addr[1:0];

    assign ram_idx = dmem_addr[RW+1:2];

    always_comb begin
        region = REG_NONE;
        if (dmem_addr[31:RW+2] == '0) begin
            region = REG_RAM;
        end else if (dmem_addr[31:2] == MMIO_OUT_DATA[31:2]) begin
            region = REG_OUT;
        end else if (dmem_addr[31:2] == MMIO_STATUS[31:2]) begin
            region = REG_STATUS;
`ifdef DMEM_MMIO_CYCLE_CNT_EN
        end else if (dmem_addr[31:2] == MMIO_CYCLES[31:2]) begin
            region = REG_CYCLES;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (dmem_we && region == REG_RAM) begin
            ram[ram_idx] <= dmem_wd;
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign pop      = out_valid && out_ready;
    assign push_req = dmem_we && region == REG_OUT;
    assign push_ok  = push_req && (!fifo_full || pop);

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .wdata (dmem_wd),
        .pop   (pop),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid = !fifo_empty;

    // STATUS write and a dropped push never coincide (one address per cycle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (dmem_we && region == REG_STATUS) begin
            overflow <= 1'b0;
        end else if (push_req && !push_ok) begin
            overflow <= 1'b1;
        end
    end

`ifdef DMEM_MMIO_CYCLE_CNT_EN
    logic [31:0] cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles <= '0;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end
`endif

    always_comb begin
        status           = '0;
        status[15:0]     = 16'(fifo_count);
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_OVF]   = overflow;
    end

    always_comb begin
        dmem_rd = '0;
        case (region)
            REG_RAM:    dmem_rd = ram[ram_idx];
            REG_STATUS: dmem_rd = status;
`ifdef DMEM_MMIO_CYCLE_CNT_EN
            REG_CYCLES: dmem_rd = cycles;
`endif
            default:    dmem_rd = '0;
        endcase
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// -----------------------------------------------------------------------------
// tb_dmem_mmio
// Directed bench for dmem_mmio with default parameters (256 RAM words,
// 8-entry output FIFO). Inputs change 1 ns after a rising edge; outputs are
// sampled before the following edge.
// -----------------------------------------------------------------------------
module tb_dmem_mmio;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wd;
    logic [31:0] dmem_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] A_OUT    = 32'hFFFF_0000;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
    localparam logic [31:0] A_CYCLES = 32'hFFFF_0008;

    dmem_mmio dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wd   (dmem_wd),
        .dmem_rd   (dmem_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        dmem_we   = 1'b1;
        dmem_addr = a;
        dmem_wd   = d;
        step();
        dmem_we   = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d);
        dmem_we   = 1'b0;
        dmem_addr = a;
        #1;
        d = dmem_rd;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst_n = 1'b0;
        dmem_we = 1'b0; dmem_addr = '0; dmem_wd = '0; out_ready = 1'b0;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        load(A_STATUS, v);
        total++; if (v !== 32'h0002_0000) begin bad++; $display("FAIL reset_status got=%h want=00020000", v); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ram();
        logic [31:0] v;
        store(32'h10, 32'hDEAD_BEEF);
        store(32'h14, 32'h1234_5678);
        load(32'h10, v);
        total++; if (v !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_rd10 got=%h want=deadbeef", v); end
        load(32'h13, v);
        total++; if (v !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_rd13 got=%h want=deadbeef", v); end
        load(32'h14, v);
        total++; if (v !== 32'h1234_5678) begin bad++; $display("FAIL ram_rd14 got=%h want=12345678", v); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] v;
        store(32'h0,   32'h1111_1111);
        store(32'h3FC, 32'h2222_2222);
        store(32'h400, 32'hFFFF_FFFF);
        load(32'h0, v);
        total++; if (v !== 32'h1111_1111) begin bad++; $display("FAIL oor_ram0 got=%h want=11111111", v); end
        load(32'h3FC, v);
        total++; if (v !== 32'h2222_2222) begin bad++; $display("FAIL oor_ram3fc got=%h want=22222222", v); end
        load(32'h400, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL oor_rd400 got=%h want=0", v); end
        load(32'h8000_0010, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL unmapped_rd got=%h want=0", v); end
        load(A_OUT, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL outdata_rd got=%h want=0", v); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL oor_no_push got=%b want=0", out_valid); end
    endtask

    task automatic test_fifo_fill();
        logic [31:0] v;
        out_ready = 1'b0;
        store(A_OUT, 32'd1);
        total++; if (out_valid !== 1'b1 || out_data !== 32'd1) begin bad++; $display("FAIL first_push got=%b/%h want=1/1", out_valid, out_data); end
        for (int i = 2; i <= 8; i++) store(A_OUT, 32'(i));
        load(A_STATUS, v);
        total++; if (v !== 32'h0001_0008) begin bad++; $display("FAIL fill_status got=%h want=00010008", v); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf got=%b want=0", overflow); end
        store(A_OUT, 32'd9);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ninth_ovf got=%b want=1", overflow); end
        load(A_STATUS, v);
        total++; if (v !== 32'h0005_0008) begin bad++; $display("FAIL ovf_status got=%h want=00050008", v); end
        total++; if (out_data !== 32'd1) begin bad++; $display("FAIL head_hold got=%h want=1", out_data); end
    endtask

    task automatic test_overflow_clear_drain();
        logic [31:0] v;
        store(A_STATUS, 32'hFFFF_FFFF);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
        load(A_STATUS, v);
        total++; if (v !== 32'h0001_0008) begin bad++; $display("FAIL clr_status got=%h want=00010008", v); end
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
                bad++; $display("FAIL drain_%0d got=%b/%h want=1/%h", i, out_valid, out_data, 32'(i));
            end
            step();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_end_valid got=%b want=0", out_valid); end
        load(A_STATUS, v);
        total++; if (v !== 32'h0002_0000) begin bad++; $display("FAIL drain_status got=%h want=00020000", v); end
        out_ready = 1'b0;
    endtask

    task automatic test_empty_same_edge();
        logic [31:0] v;
        out_ready = 1'b1;
        store(A_OUT, 32'h55);
        total++; if (out_valid !== 1'b1 || out_data !== 32'h55) begin bad++; $display("FAIL empty_push got=%b/%h want=1/55", out_valid, out_data); end
        load(A_STATUS, v);
        total++; if (v !== 32'h0000_0001) begin bad++; $display("FAIL empty_push_status got=%h want=00000001", v); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL empty_pop got=%b want=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_same_edge();
        logic [31:0] v;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) store(A_OUT, 32'h100 + 32'(i));
        out_ready = 1'b1;
        store(A_OUT, 32'hAA);
        out_ready = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_same_ovf got=%b want=0", overflow); end
        total++; if (out_data !== 32'h101) begin bad++; $display("FAIL full_same_head got=%h want=101", out_data); end
        load(A_STATUS, v);
        total++; if (v !== 32'h0001_0008) begin bad++; $display("FAIL full_same_status got=%h want=00010008", v); end
    endtask

    task automatic test_reset_counter();
        logic [31:0] v;
        logic [31:0] exp5;
        logic [31:0] exp6;
`ifdef DMEM_MMIO_CYCLE_CNT_EN
        exp5 = 32'd5;
        exp6 = 32'd6;
`else
        exp5 = 32'd0;
        exp6 = 32'd0;
`endif
        out_ready = 1'b1;
        step();
        step();
        total++; if (out_data !== 32'h103) begin bad++; $display("FAIL middrain_head got=%h want=103", out_data); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
        load(A_STATUS, v);
        total++; if (v !== 32'h0002_0000) begin bad++; $display("FAIL rst_status got=%h want=00020000", v); end
        out_ready = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        load(A_CYCLES, v);
        total++; if (v !== exp5) begin bad++; $display("FAIL cycles5 got=%h want=%h", v, exp5); end
        store(A_CYCLES, 32'h1234);
        load(A_CYCLES, v);
        total++; if (v !== exp6) begin bad++; $display("FAIL cycles_wr_ignored got=%h want=%h", v, exp6); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL cycles_no_push got=%b want=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_out_of_range();
        test_fifo_fill();
        test_overflow_clear_drain();
        test_empty_same_edge();
        test_full_same_edge();
        test_reset_counter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
